// File: rtl/sensor_frame_packer_pkg.sv
// Shared FSM encoding, frame offsets and mailbox bit positions for the sensor frame packer.
package sensor_frame_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_HDR,
      S_WR_SEQ,
      S_WR_DATA,
      S_WR_CSUM,
      S_RD_ACK,
      S_WAIT_ACK,
      S_WR_SEQ_MB,
      S_WR_MB,
      S_DONE
   } state_t;

   localparam int OFS_HDR      = 0;
   localparam int OFS_SEQ      = 1;
   localparam int MB_VALID_BIT = 7;
   localparam int MB_BANK_BIT  = 0;

   // Header + sequence + payload bytes + checksum.
   function automatic int frame_len(input int num_ch, input int ch_w);
      return 3 + (num_ch * ch_w) / 8;
   endfunction

endpackage

// File: rtl/sensor_frame_packer_if.sv
// Byte-wide fabric port (port B) of the QSPI-shared dual-port block RAM.
interface sensor_frame_packer_if #(
   parameter int ADDR_W = 32
) ();
   logic [ADDR_W-1:0] addr;
   logic [7:0]        data_out;
   logic [7:0]        data_in;
   logic              wen;

   modport master (output addr, output data_out, output wen, input data_in);
   modport slave  (input addr, input data_out, input wen, output data_in);
endinterface

// File: rtl/sensor_frame_packer_sample_trigger_gen.sv
// Single-cycle sample trigger: free-running divider, or gated external request when SAMPLE_DIV is 0.
module sample_trigger_gen #(
   parameter int SAMPLE_DIV = 100_000
) (
   input  logic clk,
   input  logic Rst,
   input  logic enable,
   input  logic sample_req,
   output logic trig
);

   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   generate
      if (SAMPLE_DIV == 0) begin : g_ext
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ Rst;
         assign trig = enable & sample_req;
      end else begin : g_int
         localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_DIV - 1);
         logic [DIV_W-1:0] div_q;
         logic [DIV_W-1:0] div_d;
         logic             unused_sample_req;

         assign unused_sample_req = sample_req;

         // Dropping enable parks the divider at zero so re-enabling gives a full period.
         always_comb begin
            div_d = div_q;
            if (!enable) begin
               div_d = '0;
            end else if (div_q == DIV_MAX) begin
               div_d = '0;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         always_ff @(posedge clk or posedge Rst) begin
            if (Rst) begin
               div_q <= '0;
            end else begin
               div_q <= div_d;
            end
         end

         assign trig = enable & (div_q == DIV_MAX);
      end
   endgenerate

endmodule

// File: rtl/sensor_frame_packer.sv
// Snapshots NUM_CH sensor channels on a trigger and writes a checksummed frame into alternating RAM banks, then commits it through a mailbox.
module sensor_frame_packer
   import sensor_frame_pkg::*;
#(
   parameter int                NUM_CH      = 7,
   parameter int                CH_W        = 16,
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BANK0_BASE  = 32'h0000_0000,
   parameter int                BANK_STRIDE = 32,
   parameter logic [ADDR_W-1:0] MB_ADDR     = 32'h0000_0040,
   parameter logic [7:0]        HDR_BYTE    = 8'hA5,
   parameter int                SAMPLE_DIV  = 100_000,
   parameter int                RD_LAT      = 1
) (
   input  logic                     clk,
   input  logic                     Rst,
   input  logic                     enable,
   input  logic                     sample_req,
   input  logic [NUM_CH*CH_W-1:0]   ch_data,
   sensor_frame_packer_if.master    ram,
   output logic                     busy,
   output logic                     frame_done,
   output logic [7:0]               seq,
   output logic [7:0]               overrun_cnt,
   output logic [7:0]               drop_cnt
);

   localparam int NB    = (NUM_CH * CH_W) / 8;
   localparam int L     = frame_len(NUM_CH, CH_W);
   localparam int CNT_W = $clog2(((NB > RD_LAT) ? NB : RD_LAT) + 1);

   localparam logic [CNT_W-1:0]  LAST_BYTE  = CNT_W'(NB - 1);
   localparam logic [CNT_W-1:0]  LAST_WAIT  = CNT_W'(RD_LAT - 1);
   localparam logic [ADDR_W-1:0] BANK1_BASE = BANK0_BASE + ADDR_W'(BANK_STRIDE);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [NUM_CH*CH_W-1:0]  snap_q, snap_d;
   logic [7:0]              csum_q, csum_d;
   logic                    bank_q, bank_d;
   logic [7:0]              seq_q, seq_d;
   logic [7:0]              overrun_q, overrun_d;
   logic [7:0]              drop_q, drop_d;

   logic                    trig;
   logic [ADDR_W-1:0]       addr_c;
   logic [7:0]              data_c;
   logic                    wen_c;
   logic [ADDR_W-1:0]       bank_base;
   logic [7:0]              seq_nxt;
   logic [7:0]              mb_byte;
   logic                    unused_data_in;

   sample_trigger_gen #(
      .SAMPLE_DIV (SAMPLE_DIV)
   ) u_trig (
      .clk        (clk),
      .Rst        (Rst),
      .enable     (enable),
      .sample_req (sample_req),
      .trig       (trig)
   );

   // Mailbox protocol: we write MB+1 = seq, then MB = {valid=1, bank}; the host
   // consumes the frame and acknowledges by clearing the valid bit. A valid bit
   // still set when we read MB back means the host missed the previous frame.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      snap_d    = snap_q;
      csum_d    = csum_q;
      bank_d    = bank_q;
      seq_d     = seq_q;
      overrun_d = overrun_q;
      drop_d    = drop_q;
      addr_c    = '0;
      data_c    = '0;
      wen_c     = 1'b0;
      bank_base = bank_q ? BANK1_BASE : BANK0_BASE;
      seq_nxt   = seq_q + 8'd1;
      mb_byte   = '0;
      mb_byte[MB_VALID_BIT] = 1'b1;
      mb_byte[MB_BANK_BIT]  = bank_q;

      if (trig && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (trig) begin
               snap_d  = ch_data;
               csum_d  = '0;
               cnt_d   = '0;
               state_d = S_WR_HDR;
            end
         end
         S_WR_HDR: begin
            addr_c  = bank_base + ADDR_W'(OFS_HDR);
            data_c  = HDR_BYTE;
            wen_c   = 1'b1;
            csum_d  = csum_q ^ HDR_BYTE;
            state_d = S_WR_SEQ;
         end
         S_WR_SEQ: begin
            addr_c  = bank_base + ADDR_W'(OFS_SEQ);
            data_c  = seq_nxt;
            wen_c   = 1'b1;
            csum_d  = csum_q ^ seq_nxt;
            state_d = S_WR_DATA;
         end
         S_WR_DATA: begin
            // Shifting the snapshot right yields channels low-first, each little-endian.
            addr_c = bank_base + ADDR_W'(OFS_SEQ + 1) + ADDR_W'(cnt_q);
            data_c = snap_q[7:0];
            wen_c  = 1'b1;
            csum_d = csum_q ^ snap_q[7:0];
            snap_d = snap_q >> 8;
            if (cnt_q == LAST_BYTE) begin
               cnt_d   = '0;
               state_d = S_WR_CSUM;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WR_CSUM: begin
            addr_c  = bank_base + ADDR_W'(L - 1);
            data_c  = csum_q;
            wen_c   = 1'b1;
            state_d = S_RD_ACK;
         end
         S_RD_ACK: begin
            addr_c  = MB_ADDR;
            cnt_d   = '0;
            state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            addr_c = MB_ADDR;
            if (cnt_q == LAST_WAIT) begin
               if (ram.data_in[MB_VALID_BIT] && (overrun_q != 8'hFF)) begin
                  overrun_d = overrun_q + 8'd1;
               end
               cnt_d   = '0;
               state_d = S_WR_SEQ_MB;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WR_SEQ_MB: begin
            addr_c  = MB_ADDR + ADDR_W'(1);
            data_c  = seq_nxt;
            wen_c   = 1'b1;
            state_d = S_WR_MB;
         end
         S_WR_MB: begin
            addr_c  = MB_ADDR;
            data_c  = mb_byte;
            wen_c   = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            seq_d   = seq_nxt;
            bank_d  = ~bank_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         snap_q    <= '0;
         csum_q    <= '0;
         bank_q    <= 1'b0;
         seq_q     <= 8'hFF;
         overrun_q <= '0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         snap_q    <= snap_d;
         csum_q    <= csum_d;
         bank_q    <= bank_d;
         seq_q     <= seq_d;
         overrun_q <= overrun_d;
         drop_q    <= drop_d;
      end
   end

   // RAM strobes decode straight from the state register, so an async reset kills wen at once.
   assign ram.addr       = addr_c;
   assign ram.data_out   = data_c;
   assign ram.wen        = wen_c;
   assign unused_data_in = ^ram.data_in;

   assign busy        = (state_q != S_IDLE);
   assign frame_done  = (state_q == S_DONE);
   assign seq         = seq_q;
   assign overrun_cnt = overrun_q;
   assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_sensor_frame_packer.sv
// Directed bench: external-trigger instance for frame/mailbox/drop/reset cases, divider instance for periodic triggers and saturation.
module tb_sensor_frame_packer;

   logic         clk = 1'b0;
   logic         rst0, rst1, ram_clr;
   logic         en0, en1, req0, req1;
   logic [111:0] ch_data0, ch_data1;
   logic         busy0, busy1, done0, done1;
   logic [7:0]   seq0, seq1, ovr0, ovr1, drop0, drop1;
   logic         host_we;
   logic [6:0]   host_addr;
   logic [7:0]   host_data;
   logic [7:0]   mem0 [0:127];
   logic [7:0]   mem1 [0:127];
   int           wcnt0;
   int           vectors = 0;
   int           miscompares = 0;

   sensor_frame_packer_if #(.ADDR_W(32)) bus0 ();
   sensor_frame_packer_if #(.ADDR_W(32)) bus1 ();

   always #5 clk = ~clk;

   sensor_frame_packer #(.SAMPLE_DIV(0)) dut0 (
      .clk(clk), .Rst(rst0), .enable(en0), .sample_req(req0), .ch_data(ch_data0),
      .ram(bus0), .busy(busy0), .frame_done(done0), .seq(seq0),
      .overrun_cnt(ovr0), .drop_cnt(drop0)
   );

   sensor_frame_packer #(.SAMPLE_DIV(10)) dut1 (
      .clk(clk), .Rst(rst1), .enable(en1), .sample_req(req1), .ch_data(ch_data1),
      .ram(bus1), .busy(busy1), .frame_done(done1), .seq(seq1),
      .overrun_cnt(ovr1), .drop_cnt(drop1)
   );

   // Block RAM model: port B for the DUT (read latency 1), port A for the QSPI host.
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 128; i++) begin
            mem0[i] <= 8'h00;
            mem1[i] <= 8'h00;
         end
         wcnt0 <= 0;
      end else begin
         if (host_we) mem0[host_addr] <= host_data;
         if (bus0.wen) begin
            mem0[bus0.addr[6:0]] <= bus0.data_out;
            wcnt0 <= wcnt0 + 1;
         end
         if (bus1.wen) mem1[bus1.addr[6:0]] <= bus1.data_out;
      end
      bus0.data_in <= mem0[bus0.addr[6:0]];
      bus1.data_in <= mem1[bus1.addr[6:0]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse0();
      req0 = 1'b1;
      tick();
      req0 = 1'b0;
   endtask

   task automatic wait_done0(output int n);
      n = 1;
      while (!done0 && n < 60) begin
         tick();
         n++;
      end
   endtask

   task automatic host_wr(input logic [6:0] a, input logic [7:0] d);
      host_we   = 1'b1;
      host_addr = a;
      host_data = d;
      tick();
      host_we = 1'b0;
   endtask

   // Frame bytes: A5, seq, 31..3E, checksum.
   task automatic chk_frame(input logic [6:0] base, input logic [7:0] s, input logic [7:0] cs);
      logic [7:0] e;
      for (int o = 0; o < 17; o++) begin
         if (o == 0)       e = 8'hA5;
         else if (o == 1)  e = s;
         else if (o == 16) e = cs;
         else              e = 8'h31 + 8'(o - 2);
         chk($sformatf("frame@%0h+%0d", base, o), {24'h0, mem0[base + 7'(o)]}, {24'h0, e});
      end
   endtask

   initial begin
      int n, w_start, cyc, nh, nd, first_hdr, first_done, last_done, late;

      rst0 = 1'b1; rst1 = 1'b1; ram_clr = 1'b1;
      en0 = 1'b1; en1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
      host_we = 1'b0; host_addr = '0; host_data = '0;
      ch_data0 = 112'h3E3D_3C3B_3A39_3837_3635_3433_3231;
      ch_data1 = 112'h3E3D_3C3B_3A39_3837_3635_3433_3231;
      repeat (3) tick();
      rst0 = 1'b0; rst1 = 1'b0; ram_clr = 1'b0;

      chk("rst_addr", bus0.addr, 32'h0);
      chk("rst_data_out", {24'h0, bus0.data_out}, 32'h0);
      chk("rst_wen", {31'h0, bus0.wen}, 32'h0);
      chk("rst_busy", {31'h0, busy0}, 32'h0);
      chk("rst_frame_done", {31'h0, done0}, 32'h0);
      chk("rst_seq", {24'h0, seq0}, 32'hFF);
      chk("rst_overrun", {24'h0, ovr0}, 32'h0);
      chk("rst_drop", {24'h0, drop0}, 32'h0);

      // Request ignored while disabled.
      en0 = 1'b0;
      pulse0();
      repeat (3) tick();
      chk("disabled_busy", {31'h0, busy0}, 32'h0);
      en0 = 1'b1;

      // Frame 1: bank 0, seq 00, checksum AA.
      w_start = wcnt0;
      pulse0();
      chk("f1_busy", {31'h0, busy0}, 32'h1);
      chk("f1_hdr_wen", {31'h0, bus0.wen}, 32'h1);
      chk("f1_hdr_addr", bus0.addr, 32'h0);
      chk("f1_hdr_data", {24'h0, bus0.data_out}, 32'hA5);
      wait_done0(n);
      chk("f1_latency", n, 22);
      tick();
      chk("f1_busy_after", {31'h0, busy0}, 32'h0);
      chk("f1_seq", {24'h0, seq0}, 32'h00);
      chk_frame(7'h00, 8'h00, 8'hAA);
      chk("f1_mb", {24'h0, mem0[7'h40]}, 32'h80);
      chk("f1_mb_seq", {24'h0, mem0[7'h41]}, 32'h00);
      chk("f1_writes", wcnt0 - w_start, 19);
      chk("f1_overrun", {24'h0, ovr0}, 32'h0);

      // Frame 2: no ack -> bank 1, overrun; snapshot must ignore later ch_data changes.
      pulse0();
      ch_data0 = '1;
      wait_done0(n);
      tick();
      ch_data0 = 112'h3E3D_3C3B_3A39_3837_3635_3433_3231;
      chk_frame(7'h20, 8'h01, 8'hAB);
      chk("f2_mb", {24'h0, mem0[7'h40]}, 32'h81);
      chk("f2_mb_seq", {24'h0, mem0[7'h41]}, 32'h01);
      chk("f2_overrun", {24'h0, ovr0}, 32'h1);
      chk("f2_seq", {24'h0, seq0}, 32'h01);

      // Frame 3: host acks first -> bank 0 again, overrun unchanged.
      host_wr(7'h40, 8'h00);
      pulse0();
      wait_done0(n);
      tick();
      chk("f3_seq_byte", {24'h0, mem0[7'h01]}, 32'h02);
      chk("f3_csum", {24'h0, mem0[7'h10]}, 32'hA8);
      chk("f3_mb", {24'h0, mem0[7'h40]}, 32'h80);
      chk("f3_overrun", {24'h0, ovr0}, 32'h1);
      chk("f3_seq", {24'h0, seq0}, 32'h02);

      // Frame 4: requests 5 cycles in and on the DONE cycle are both dropped.
      host_wr(7'h40, 8'h00);
      w_start = wcnt0;
      pulse0();
      repeat (4) tick();
      pulse0();
      wait_done0(n);
      chk("f4_done_seen", {31'h0, done0}, 32'h1);
      pulse0();
      repeat (30) tick();
      chk("f4_drop", {24'h0, drop0}, 32'h2);
      chk("f4_writes", wcnt0 - w_start, 19);
      chk("f4_busy", {31'h0, busy0}, 32'h0);
      chk("f4_seq", {24'h0, seq0}, 32'h03);
      chk("f4_csum", {24'h0, mem0[7'h30]}, 32'hA9);
      chk("f4_mb", {24'h0, mem0[7'h40]}, 32'h81);
      chk("f4_overrun", {24'h0, ovr0}, 32'h1);

      // Frame 5: bank 0, seq 04.
      host_wr(7'h40, 8'h00);
      pulse0();
      wait_done0(n);
      tick();
      chk("f5_csum", {24'h0, mem0[7'h10]}, 32'hAE);
      chk("f5_mb", {24'h0, mem0[7'h40]}, 32'h80);
      chk("f5_mb_seq", {24'h0, mem0[7'h41]}, 32'h04);

      // Frame 6 (bank 1) aborted by reset at payload byte 6.
      pulse0();
      repeat (8) tick();
      chk("f6_pre_wen", {31'h0, bus0.wen}, 32'h1);
      chk("f6_pre_addr", bus0.addr, 32'h28);
      #2 rst0 = 1'b1;
      #1;
      chk("rst_mid_wen", {31'h0, bus0.wen}, 32'h0);
      chk("rst_mid_busy", {31'h0, busy0}, 32'h0);
      tick();
      rst0 = 1'b0;
      tick();
      chk("abort_seq", {24'h0, seq0}, 32'hFF);
      chk("abort_drop", {24'h0, drop0}, 32'h0);
      chk("abort_overrun", {24'h0, ovr0}, 32'h0);
      chk("abort_mb", {24'h0, mem0[7'h40]}, 32'h80);
      chk("abort_mb_seq", {24'h0, mem0[7'h41]}, 32'h04);

      // Frame 7 after reset: bank pointer back to 0, seq byte 00.
      for (int o = 0; o < 17; o++) host_wr(7'(o), 8'h00);
      host_wr(7'h40, 8'h00);
      w_start = wcnt0;
      pulse0();
      chk("f7_hdr_addr", bus0.addr, 32'h0);
      wait_done0(n);
      chk("f7_latency", n, 22);
      tick();
      chk_frame(7'h00, 8'h00, 8'hAA);
      chk("f7_mb", {24'h0, mem0[7'h40]}, 32'h80);
      chk("f7_mb_seq", {24'h0, mem0[7'h41]}, 32'h00);
      chk("f7_seq", {24'h0, seq0}, 32'h00);
      chk("f7_writes", wcnt0 - w_start, 19);

      // Divider instance: enable for cycles 0..99, triggers at 9,19,...; period 30 accepted.
      en1 = 1'b1;
      cyc = 0; nh = 0; nd = 0; first_hdr = -1; first_done = -1; last_done = -1; late = 0;
      while (cyc < 160) begin
         tick();
         cyc++;
         if (cyc == 100) en1 = 1'b0;
         if (bus1.wen && (bus1.addr == 32'h0 || bus1.addr == 32'h20)) begin
            nh++;
            if (first_hdr < 0) first_hdr = cyc;
         end
         if (done1) begin
            nd++;
            if (first_done < 0) first_done = cyc;
            last_done = cyc;
         end
         if (cyc > 122 && bus1.wen) late++;
      end
      chk("div_first_hdr", first_hdr, 10);
      chk("div_first_done", first_done, 31);
      chk("div_headers", nh, 4);
      chk("div_frames", nd, 4);
      chk("div_last_done", last_done, 121);
      chk("div_idle_writes", late, 0);
      chk("div_drop", {24'h0, drop1}, 32'h6);
      chk("div_overrun", {24'h0, ovr1}, 32'h3);
      chk("div_seq", {24'h0, seq1}, 32'h03);

      // 267 more unacked frames: both counters saturate, seq wraps to 0x0E.
      en1 = 1'b1;
      cyc = 0;
      while (cyc < 8060) begin
         tick();
         cyc++;
         if (cyc == 8000) en1 = 1'b0;
      end
      chk("sat_overrun", {24'h0, ovr1}, 32'hFF);
      chk("sat_drop", {24'h0, drop1}, 32'hFF);
      chk("wrap_seq", {24'h0, seq1}, 32'h0E);
      chk("sat_busy", {31'h0, busy1}, 32'h0);
      chk("sat_mb", {24'h0, mem1[7'h40]}, 32'h80);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
